// File: rtl/hsstl_rst4mcrsw_tx_init_v1_0.sv
// ============================================================================
// hsstl_rst4mcrsw_tx_init_v1_0
// ----------------------------------------------------------------------------
// Per-lane TX reset / initialisation sequencer for the HSST PCIe PIPE lane.
//
// After lane powerup and a debounced PLL lock, the PMA TX reset and then the
// PCS TX reset are released in order. Losing the PLL lock sends the lane back
// to wait for a new lock. A Gen1/Gen2 rate request is applied while the TX PCS
// is held in reset. init_done tells the multi-lane reset controller that the
// lane TX side is ready.
//
// Optional feature macro: HSSTL_TX_INIT_TIMEOUT_EN
//   Defined     : a lock-wait watchdog runs in WAIT_PLL. If the counter reaches
//                 TIMEOUT_CNT without a debounced lock, pll_rst_req pulses for
//                 one cycle and the wait restarts.
//   Not defined : no watchdog. pll_rst_req is tied to 0 and WAIT_PLL waits
//                 indefinitely.
//
// Ports
//   clk               in   lane reference/user clock
//   rst               in   asynchronous active-high reset
//   txlane_soft_rst   in   synchronous active-high soft reset
//   P_TX_LANE_POWERUP in   lane powered; low forces IDLE
//   P_PLL_LOCK        in   asynchronous HSST PLL lock
//   cur_rate          in   requested rate (0 = 2.5G, 1 = 5G)
//   tx_init_fsm       out  current state encoding (3 bits)
//   s_PLL_LOCK        out  synchronised PLL lock
//   s_PLL_LOCK_deb    out  debounced PLL lock
//   P_TX_PMA_RSTN     out  PMA TX reset, active low
//   P_PCS_TX_RSTN     out  PCS TX reset, active low
//   P_TX_RATE         out  rate applied to the HSST
//   pll_rst_req       out  one-cycle PLL reset request (watchdog build only)
//   init_done         out  lane TX ready
// ============================================================================
module hsstl_rst4mcrsw_tx_init_v1_0 #(
    parameter int PLL_DEB_CNT    = 2048,
    parameter int PMA_RST_CNT    = 64,
    parameter int PMA_SETTLE_CNT = 256,
    parameter int RATE_SW_CNT    = 32
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CNT    = 4000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txlane_soft_rst,
    input  logic       P_TX_LANE_POWERUP,
    input  logic       P_PLL_LOCK,
    input  logic       cur_rate,
    output logic [2:0] tx_init_fsm,
    output logic       s_PLL_LOCK,
    output logic       s_PLL_LOCK_deb,
    output logic       P_TX_PMA_RSTN,
    output logic       P_PCS_TX_RSTN,
    output logic       P_TX_RATE,
    output logic       pll_rst_req,
    output logic       init_done
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PLL = 3'd1,
        ST_PMA_RST  = 3'd2,
        ST_WAIT_PMA = 3'd3,
        ST_DONE     = 3'd4,
        ST_RATE_CHG = 3'd5
    } state_t;

    localparam logic [11:0] CNT_MAX      = 12'hFFF;
    localparam logic [11:0] DEB_TERM     = 12'(PLL_DEB_CNT);
    // A state lasting N cycles exits when the counter shows N-1, because the
    // counter is cleared on the entry edge itself.
    localparam logic [11:0] PMA_RST_LAST = 12'(PMA_RST_CNT - 1);
    localparam logic [11:0] SETTLE_LAST  = 12'(PMA_SETTLE_CNT - 1);
    localparam logic [11:0] RATE_SW_LAST = 12'(RATE_SW_CNT - 1);
    localparam logic [11:0] RATE_HALF    = 12'((RATE_SW_CNT / 2) - 1);
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
    localparam logic [11:0] TIMEOUT_TERM = 12'(TIMEOUT_CNT);
`endif

    // Saturating increment: counters park at their terminal value.
    function automatic logic [11:0] sat_inc(input logic [11:0] value);
        logic [11:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 12'd1;
        end
        return result;
    endfunction

    logic        lock_meta_r;
    logic [11:0] deb_cnt_r;
    state_t      state_r;
    logic [11:0] cnt_r;
    logic        lock_needed_s;
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
    logic        pll_rst_req_r;
`endif

    assign tx_init_fsm = state_r;

    // States that hold a released or releasing PMA and must fall back on lock loss.
    assign lock_needed_s = (state_r == ST_PMA_RST)  || (state_r == ST_WAIT_PMA) ||
                           (state_r == ST_DONE)     || (state_r == ST_RATE_CHG);

`ifdef HSSTL_TX_INIT_TIMEOUT_EN
    assign pll_rst_req = pll_rst_req_r;
`else
    assign pll_rst_req = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous PLL lock input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            s_PLL_LOCK  <= 1'b0;
        end else if (txlane_soft_rst) begin
            lock_meta_r <= 1'b0;
            s_PLL_LOCK  <= 1'b0;
        end else begin
            lock_meta_r <= P_PLL_LOCK;
            s_PLL_LOCK  <= lock_meta_r;
        end
    end

    // Lock debounce: count consecutive locked cycles, drop at once on any gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_r      <= 12'd0;
            s_PLL_LOCK_deb <= 1'b0;
        end else if (txlane_soft_rst) begin
            deb_cnt_r      <= 12'd0;
            s_PLL_LOCK_deb <= 1'b0;
        end else begin
            if (!s_PLL_LOCK) begin
                deb_cnt_r <= 12'd0;
            end else if (deb_cnt_r != DEB_TERM) begin
                deb_cnt_r <= deb_cnt_r + 12'd1;
            end else begin
                deb_cnt_r <= deb_cnt_r;
            end
            s_PLL_LOCK_deb <= s_PLL_LOCK && (deb_cnt_r == DEB_TERM);
        end
    end

    // Sequencer: state, state counter and every registered reset/status output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 12'd0;
            P_TX_PMA_RSTN <= 1'b0;
            P_PCS_TX_RSTN <= 1'b0;
            P_TX_RATE     <= 1'b0;
            init_done     <= 1'b0;
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
            pll_rst_req_r <= 1'b0;
`endif
        end else if (txlane_soft_rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 12'd0;
            P_TX_PMA_RSTN <= 1'b0;
            P_PCS_TX_RSTN <= 1'b0;
            P_TX_RATE     <= 1'b0;
            init_done     <= 1'b0;
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
            pll_rst_req_r <= 1'b0;
`endif
        end else begin
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
            // Request is a single-cycle pulse unless re-armed below.
            pll_rst_req_r <= 1'b0;
`endif
            if (!P_TX_LANE_POWERUP) begin
                // Powerdown overrides everything.
                state_r       <= ST_IDLE;
                cnt_r         <= 12'd0;
                P_TX_PMA_RSTN <= 1'b0;
                P_PCS_TX_RSTN <= 1'b0;
                init_done     <= 1'b0;
            end else if (!s_PLL_LOCK && lock_needed_s) begin
                // Lock loss beats any pending rate change; the new rate is
                // picked up at the next WAIT_PMA exit.
                state_r       <= ST_WAIT_PLL;
                cnt_r         <= 12'd0;
                P_TX_PMA_RSTN <= 1'b0;
                P_PCS_TX_RSTN <= 1'b0;
                init_done     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r       <= ST_WAIT_PLL;
                        cnt_r         <= 12'd0;
                        P_TX_PMA_RSTN <= 1'b0;
                        P_PCS_TX_RSTN <= 1'b0;
                        init_done     <= 1'b0;
                    end
                    ST_WAIT_PLL: begin
                        // The raw synchronised lock is also required so a
                        // debounced flag that has not yet dropped is ignored.
                        if (s_PLL_LOCK_deb && s_PLL_LOCK) begin
                            state_r       <= ST_PMA_RST;
                            cnt_r         <= 12'd0;
                            P_TX_PMA_RSTN <= 1'b0;
                            P_PCS_TX_RSTN <= 1'b0;
                            init_done     <= 1'b0;
                        end
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
                        else if (cnt_r == TIMEOUT_TERM) begin
                            pll_rst_req_r <= 1'b1;
                            cnt_r         <= 12'd0;
                        end
`endif
                        else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                    ST_PMA_RST: begin
                        if (cnt_r == PMA_RST_LAST) begin
                            state_r       <= ST_WAIT_PMA;
                            cnt_r         <= 12'd0;
                            P_TX_PMA_RSTN <= 1'b1;
                            P_PCS_TX_RSTN <= 1'b0;
                            init_done     <= 1'b0;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                    ST_WAIT_PMA: begin
                        if (cnt_r == SETTLE_LAST) begin
                            state_r       <= ST_DONE;
                            cnt_r         <= 12'd0;
                            P_TX_PMA_RSTN <= 1'b1;
                            P_PCS_TX_RSTN <= 1'b1;
                            P_TX_RATE     <= cur_rate;
                            init_done     <= 1'b1;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                    ST_DONE: begin
                        if (cur_rate != P_TX_RATE) begin
                            state_r       <= ST_RATE_CHG;
                            cnt_r         <= 12'd0;
                            P_TX_PMA_RSTN <= 1'b1;
                            P_PCS_TX_RSTN <= 1'b0;
                            init_done     <= 1'b0;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                        end
                    end
                    ST_RATE_CHG: begin
                        if (cnt_r == RATE_SW_LAST) begin
                            // DONE re-compares, so a rate that toggled back
                            // after the midpoint triggers another pass.
                            state_r       <= ST_DONE;
                            cnt_r         <= 12'd0;
                            P_TX_PMA_RSTN <= 1'b1;
                            P_PCS_TX_RSTN <= 1'b1;
                            init_done     <= 1'b1;
                        end else begin
                            cnt_r <= sat_inc(cnt_r);
                            if (cnt_r == RATE_HALF) begin
                                // Rate changes mid-way through the PCS reset window.
                                P_TX_RATE <= cur_rate;
                            end else begin
                                P_TX_RATE <= P_TX_RATE;
                            end
                        end
                    end
                    default: begin
                        state_r       <= ST_IDLE;
                        cnt_r         <= 12'd0;
                        P_TX_PMA_RSTN <= 1'b0;
                        P_PCS_TX_RSTN <= 1'b0;
                        init_done     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hsstl_rst4mcrsw_tx_init_v1_0.sv
// Directed bench for the lane TX init sequencer: a vector table for steady
// checkpoints plus hand-written sequences for the timed corner cases.
module tb_hsstl_rst4mcrsw_tx_init_v1_0;

    logic       clk;
    logic       rst;
    logic       txlane_soft_rst;
    logic       P_TX_LANE_POWERUP;
    logic       P_PLL_LOCK;
    logic       cur_rate;
    logic [2:0] tx_init_fsm;
    logic       s_PLL_LOCK;
    logic       s_PLL_LOCK_deb;
    logic       P_TX_PMA_RSTN;
    logic       P_PCS_TX_RSTN;
    logic       P_TX_RATE;
    logic       pll_rst_req;
    logic       init_done;

    int n_checks = 0;
    int n_pass   = 0;

    hsstl_rst4mcrsw_tx_init_v1_0 #(
        .PLL_DEB_CNT(2048)
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
        , .TIMEOUT_CNT(100)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .txlane_soft_rst  (txlane_soft_rst),
        .P_TX_LANE_POWERUP(P_TX_LANE_POWERUP),
        .P_PLL_LOCK       (P_PLL_LOCK),
        .cur_rate         (cur_rate),
        .tx_init_fsm      (tx_init_fsm),
        .s_PLL_LOCK       (s_PLL_LOCK),
        .s_PLL_LOCK_deb   (s_PLL_LOCK_deb),
        .P_TX_PMA_RSTN    (P_TX_PMA_RSTN),
        .P_PCS_TX_RSTN    (P_PCS_TX_RSTN),
        .P_TX_RATE        (P_TX_RATE),
        .pll_rst_req      (pll_rst_req),
        .init_done        (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        pu;
        logic        lock;
        logic        rate;
        logic [15:0] adv;
        logic [2:0]  st;
        logic        pma;
        logic        pcs;
        logic        txr;
        logic        done;
    } vec_t;

    vec_t vecs [0:6];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    // Step until the state matches, giving up after bound edges.
    task automatic wait_state(input logic [2:0] tgt, input int bound, input string nm, output int n);
        n = 0;
        while (tx_init_fsm != tgt && n < bound) begin
            step(1);
            n++;
        end
        chk(nm, int'(tx_init_fsm), int'(tgt));
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            P_TX_LANE_POWERUP = vecs[i].pu;
            P_PLL_LOCK        = vecs[i].lock;
            cur_rate          = vecs[i].rate;
            step(int'(vecs[i].adv));
            chk($sformatf("vec%0d{st,pma,pcs,rate,done}", i),
                int'({tx_init_fsm, P_TX_PMA_RSTN, P_PCS_TX_RSTN, P_TX_RATE, init_done}),
                int'({vecs[i].st, vecs[i].pma, vecs[i].pcs, vecs[i].txr, vecs[i].done}));
        end
    endtask

    initial begin
        int n;
        int t_s, t_deb, t_st2, t_st3, t_st4, t5, t_rate, t4;
        logic pma_at3, pcs_at3, pcs_at4, done_at4, pcs_at5, done_at5;
        logic early, pma_low, done_in5;
        int pulses [$];
        logic prev, consec;

        //            pu    lock  rate  adv     st    pma   pcs   txr   done
        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'd4,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 16'd3,   3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'd300, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 16'd2,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'd2,   3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'd50,  3'd4, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 16'd20,  3'd4, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; txlane_soft_rst = 1'b0;
        P_TX_LANE_POWERUP = 1'b0; P_PLL_LOCK = 1'b0; cur_rate = 1'b0;
        step(3);
        chk("reset_outputs", int'({tx_init_fsm, s_PLL_LOCK, s_PLL_LOCK_deb, P_TX_PMA_RSTN,
                                   P_PCS_TX_RSTN, P_TX_RATE, pll_rst_req, init_done}), 0);
        rst = 1'b0;
        run_vecs(0, 4);

        // Bring-up with steady lock: sync, debounce, PMA window, settle window.
        t_s = -1; t_deb = -1; t_st2 = -1; t_st3 = -1; t_st4 = -1; early = 1'b0;
        pma_at3 = 1'b0; pcs_at3 = 1'b1; pcs_at4 = 1'b0; done_at4 = 1'b0;
        P_PLL_LOCK = 1'b1;
        for (int e = 1; e <= 3000 && t_st4 < 0; e++) begin
            step(1);
            if (t_s < 0 && s_PLL_LOCK) t_s = e;
            if (t_deb < 0 && s_PLL_LOCK_deb) t_deb = e;
            if (t_st2 < 0 && tx_init_fsm == 3'd2) t_st2 = e;
            if (t_st3 < 0 && tx_init_fsm == 3'd3) begin
                t_st3 = e; pma_at3 = P_TX_PMA_RSTN; pcs_at3 = P_PCS_TX_RSTN;
            end
            if (t_st4 < 0 && tx_init_fsm == 3'd4) begin
                t_st4 = e; pcs_at4 = P_PCS_TX_RSTN; done_at4 = init_done;
            end
            if ((tx_init_fsm < 3'd3 && P_TX_PMA_RSTN) || (tx_init_fsm != 3'd4 && init_done))
                early = 1'b1;
        end
        chk("sync_latency", t_s, 2);
        chk_rng("debounce_rise", t_deb, 2048, 2054);
        chk_rng("pma_release_time", t_st3, 2112, 2120);
        chk("pma_rst_len", t_st3 - t_st2, 64);
        chk("pma_settle_len", t_st4 - t_st3, 256);
        chk("wait_pma_outputs{pma,pcs}", int'({pma_at3, pcs_at3}), 2);
        chk("done_outputs{pcs,done}", int'({pcs_at4, done_at4}), 3);
        chk("no_early_release", int'(early), 0);
        run_vecs(5, 5);

        // One-cycle lock glitch in DONE: back to WAIT_PLL and full re-debounce.
        P_PLL_LOCK = 1'b0; step(1); P_PLL_LOCK = 1'b1;
        wait_state(3'd1, 8, "glitch_to_wait_pll", n);
        chk_rng("glitch_reaction", n, 1, 4);
        chk("glitch_outputs{pma,pcs,done,deb}",
            int'({P_TX_PMA_RSTN, P_PCS_TX_RSTN, init_done, s_PLL_LOCK_deb}), 0);
        wait_state(3'd2, 2200, "glitch_redebounce", n);
        chk_rng("glitch_redebounce_len", n, 2046, 2056);
        wait_state(3'd4, 400, "glitch_back_done", n);

        // Rate change 0->1 in DONE.
        t5 = -1; t_rate = -1; t4 = -1; pma_low = 1'b0; done_in5 = 1'b0;
        pcs_at5 = 1'b1; done_at5 = 1'b1;
        cur_rate = 1'b1;
        for (int e = 1; e <= 80 && t4 < 0; e++) begin
            step(1);
            if (!P_TX_PMA_RSTN) pma_low = 1'b1;
            if (tx_init_fsm == 3'd5 && init_done) done_in5 = 1'b1;
            if (t5 < 0 && tx_init_fsm == 3'd5) begin
                t5 = e; pcs_at5 = P_PCS_TX_RSTN; done_at5 = init_done;
            end
            if (t_rate < 0 && P_TX_RATE) t_rate = e;
            if (t5 >= 0 && t4 < 0 && tx_init_fsm == 3'd4) t4 = e;
        end
        chk("ratechg_entry", t5, 1);
        chk("ratechg_entry{pcs,done}", int'({pcs_at5, done_at5}), 0);
        chk("ratechg_rate_at_half", t_rate - t5, 16);
        chk("ratechg_pcs_low_len", t4 - t5, 32);
        chk("ratechg_pma_stays_high", int'(pma_low), 0);
        chk("ratechg_done_low", int'(done_in5), 0);
        chk("ratechg_restored{pcs,done}", int'({P_PCS_TX_RSTN, init_done}), 3);

        // Rate toggles back before the midpoint: sequence completes, no rerun.
        cur_rate = 1'b0; step(5); cur_rate = 1'b1; step(40);
        chk("toggle_early{st,rate,done}", int'({tx_init_fsm, P_TX_RATE, init_done}), 'b100_1_1);
        // Rate toggles back after the midpoint: DONE re-enters RATE_CHG.
        cur_rate = 1'b0; step(20); cur_rate = 1'b1; step(20);
        chk("toggle_late_rerun{st,rate}", int'({tx_init_fsm, P_TX_RATE}), 'b101_0);
        step(40);
        chk("toggle_late_final{st,rate,done}", int'({tx_init_fsm, P_TX_RATE, init_done}), 'b100_1_1);
        run_vecs(6, 6);

        // Lock loss and rate change seen on the same edge.
        P_PLL_LOCK = 1'b0; step(2); cur_rate = 1'b0; step(1);
        chk("lockloss_wins{st,rate}", int'({tx_init_fsm, P_TX_RATE}), 'b001_1);
        P_PLL_LOCK = 1'b1;
        early = 1'b0; n = 0;
        while (tx_init_fsm != 3'd4 && n < 2600) begin
            step(1); n++;
            if (tx_init_fsm != 3'd4 && P_TX_RATE != 1'b1) early = 1'b1;
        end
        chk("lockloss_rate_held", int'(early), 0);
        chk("lockloss_rate_at_exit{st,rate}", int'({tx_init_fsm, P_TX_RATE}), 'b100_0);

        // Powerup dropped mid WAIT_PMA.
        P_PLL_LOCK = 1'b0; step(1); P_PLL_LOCK = 1'b1;
        wait_state(3'd3, 2300, "reach_wait_pma", n);
        step(100);
        P_TX_LANE_POWERUP = 1'b0; step(1);
        chk("pu_drop{st,pma,pcs,done}", int'({tx_init_fsm, P_TX_PMA_RSTN, P_PCS_TX_RSTN, init_done}), 0);
        P_TX_LANE_POWERUP = 1'b1;
        wait_state(3'd4, 600, "pu_back_done", n);

        // Async reset mid RATE_CHG takes effect without a clock edge.
        cur_rate = 1'b1; step(10);
        chk("in_rate_chg", int'(tx_init_fsm), 5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", int'({tx_init_fsm, s_PLL_LOCK, s_PLL_LOCK_deb, P_TX_PMA_RSTN,
                                       P_PCS_TX_RSTN, P_TX_RATE, pll_rst_req, init_done}), 0);
        step(2); rst = 1'b0; cur_rate = 1'b0;

        // Soft reset acts on the next edge.
        step(5);
        chk("pre_soft{st,slock}", int'({tx_init_fsm, s_PLL_LOCK}), 'b001_1);
        txlane_soft_rst = 1'b1; step(1);
        chk("soft_rst{st,slock}", int'({tx_init_fsm, s_PLL_LOCK}), 0);
        txlane_soft_rst = 1'b0;
        P_PLL_LOCK = 1'b0; step(3);

        // Lock never arrives: watchdog behaviour.
        prev = 1'b0; consec = 1'b0;
        for (int e = 1; e <= 400; e++) begin
            step(1);
            if (pll_rst_req) begin
                if (prev) consec = 1'b1;
                pulses.push_back(e);
            end
            prev = pll_rst_req;
        end
`ifdef HSSTL_TX_INIT_TIMEOUT_EN
        chk_rng("timeout_pulse_count", pulses.size(), 3, 4);
        if (pulses.size() >= 2) chk("timeout_period", pulses[1] - pulses[0], 101);
        else chk("timeout_period", 0, 101);
        chk("timeout_pulse_width", int'(consec), 0);
`else
        chk("no_watchdog_pulses", pulses.size(), 0);
`endif
        chk("nolock_stays_wait_pll", int'(tx_init_fsm), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
